seq_signed_mult: RTL and testbench

- Iterative shift-add multiplier with parametrised operand widths.
- Each operand is individually signed or unsigned, selected per transaction.
- Valid/ready handshake on the input and output sides.
- Successor to the combinational fixed-width multipliers: one partial product per cycle, one adder instead of an array. Used where area matters more than throughput.

---
 rtl/seq_signed_mult_if.sv | 28 ++
 rtl/seq_signed_mult.sv | 99 +++++++++
 tb/tb_seq_signed_mult.sv | 189 ++++++++++++++++++
 3 files changed

// File: rtl/seq_signed_mult_if.sv
// seq_signed_mult_if: handshake bundle for the sequential signed multiplier.
//   master (operand source / result sink) drives in_valid, a, b, a_signed,
//   b_signed, out_ready; slave (multiplier) drives in_ready, out_valid, p, busy.
interface seq_signed_mult_if #(
  parameter int A_W = 16,
  parameter int B_W = 8
);
  logic               in_valid;
  logic               in_ready;
  logic [A_W-1:0]     a;
  logic [B_W-1:0]     b;
  logic               a_signed;
  logic               b_signed;
  logic               out_valid;
  logic               out_ready;
  logic [A_W+B_W-1:0] p;
  logic               busy;

  modport master (
    output in_valid, a, b, a_signed, b_signed, out_ready,
    input  in_ready, out_valid, p, busy
  );

  modport slave (
    input  in_valid, a, b, a_signed, b_signed, out_ready,
    output in_ready, out_valid, p, busy
  );
endinterface

// File: rtl/seq_signed_mult.sv
// seq_signed_mult: iterative shift-add multiplier, one partial product per
// cycle, each operand independently signed or unsigned per transaction.
// Ports:
//   clk  - clock, all state changes on the rising edge
//   rst  - synchronous active-high reset, aborts any operation in flight
//   bus  - seq_signed_mult_if.slave: in_valid/in_ready operand handshake
//          (a, b, a_signed, b_signed), out_valid/out_ready result handshake
//          (p), busy status
module seq_signed_mult #(
  parameter int A_W   = 16,
  parameter int B_W   = 8,
  parameter int CNT_W = 6
) (
  input  logic               clk,
  input  logic               rst,
  seq_signed_mult_if.slave   bus
);

  localparam int P_W   = A_W + B_W;
  localparam int ACC_W = P_W + 2;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(B_W);

  typedef enum logic [1:0] {S_IDLE, S_CALC, S_DONE} state_t;

  state_t           state_reg;
  logic [ACC_W-1:0] acc_reg;
  logic [ACC_W-1:0] acc_next;
  // Sign-extended multiplicand, shifted left one place per step so the
  // current partial product is always either mcand_reg or zero.
  logic [ACC_W-1:0] mcand_reg;
  // Extended multiplier, shifted right one place per step; bit 0 is the
  // multiplier bit for the current step.
  logic [B_W:0]     mplier_reg;
  logic [CNT_W-1:0] cnt_reg;
  logic [P_W-1:0]   p_reg;
  logic             out_valid_reg;

  logic [A_W:0]     ae;
  logic [B_W:0]     be;
  logic [ACC_W-1:0] pp;

  always_comb begin
    ae = {bus.a_signed & bus.a[A_W-1], bus.a};
    be = {bus.b_signed & bus.b[B_W-1], bus.b};
    pp = mplier_reg[0] ? mcand_reg : '0;
    // The top bit of be carries negative weight, so its step subtracts.
    acc_next = (cnt_reg == LAST_CNT) ? (acc_reg - pp) : (acc_reg + pp);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg     <= S_IDLE;
      acc_reg       <= '0;
      mcand_reg     <= '0;
      mplier_reg    <= '0;
      cnt_reg       <= '0;
      p_reg         <= '0;
      out_valid_reg <= 1'b0;
    end else begin
      case (state_reg)
        S_IDLE: begin
          if (bus.in_valid) begin
            mcand_reg  <= {{(ACC_W-A_W-1){ae[A_W]}}, ae};
            mplier_reg <= be;
            acc_reg    <= '0;
            cnt_reg    <= '0;
            state_reg  <= S_CALC;
          end
        end
        S_CALC: begin
          acc_reg    <= acc_next;
          mcand_reg  <= mcand_reg << 1;
          mplier_reg <= mplier_reg >> 1;
          cnt_reg    <= cnt_reg + 1'b1;
          if (cnt_reg == LAST_CNT) begin
            // The exact product always fits in P_W bits, so dropping the
            // two guard bits loses nothing.
            p_reg         <= acc_next[P_W-1:0];
            out_valid_reg <= 1'b1;
            state_reg     <= S_DONE;
          end
        end
        S_DONE: begin
          if (bus.out_ready) begin
            out_valid_reg <= 1'b0;
            state_reg     <= S_IDLE;
          end
        end
        default: state_reg <= S_IDLE;
      endcase
    end
  end

  assign bus.in_ready  = (state_reg == S_IDLE);
  assign bus.busy      = (state_reg != S_IDLE);
  assign bus.out_valid = out_valid_reg;
  assign bus.p         = p_reg;

endmodule

// File: tb/tb_seq_signed_mult.sv
// tb_seq_signed_mult: directed and random checks of seq_signed_mult with a
// scoreboard queue of expected products filled at accept, drained at output.
module tb_seq_signed_mult;
  localparam int A_W   = 16;
  localparam int B_W   = 8;
  localparam int CNT_W = 6;
  localparam int P_W   = A_W + B_W;
  localparam int LAT   = B_W + 1;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  seq_signed_mult_if #(.A_W(A_W), .B_W(B_W)) bus ();

  seq_signed_mult #(.A_W(A_W), .B_W(B_W), .CNT_W(CNT_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_tests = 0;
  int n_fail  = 0;
  logic [P_W-1:0] exp_q[$];

  function automatic logic [P_W-1:0] ref_prod(input logic [A_W-1:0] a,
                                               input logic [B_W-1:0] b,
                                               input logic as, input logic bs);
    longint ax, bx, pr;
    ax = longint'(a);
    bx = longint'(b);
    if (as && a[A_W-1]) ax = ax - (longint'(1) << A_W);
    if (bs && b[B_W-1]) bx = bx - (longint'(1) << B_W);
    pr = ax * bx;
    return pr[P_W-1:0];
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Offer an operation at a falling edge once in_ready is seen; returns just
  // after the accepting rising edge.
  task automatic start_op(input logic [A_W-1:0] a, input logic [B_W-1:0] b,
                          input logic as, input logic bs);
    int n;
    n = 0;
    @(negedge clk);
    while (!bus.in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (n >= 50) check("in_ready timeout", 64'd0, 64'd1);
    bus.a = a; bus.b = b; bus.a_signed = as; bus.b_signed = bs;
    bus.in_valid = 1'b1;
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    exp_q.push_back(ref_prod(a, b, as, bs));
  endtask

  // Count rising edges until out_valid is seen (sampled 1 time unit later).
  task automatic wait_out(output int lat);
    lat = 0;
    for (int i = 1; i <= 100; i++) begin
      @(posedge clk);
      #1;
      if (bus.out_valid) begin
        lat = i;
        break;
      end
    end
    if (lat == 0) check("out_valid timeout", 64'd0, 64'd1);
  endtask

  task automatic finish_op(input string tag, input int stall);
    logic [P_W-1:0] p0, e;
    repeat (stall) begin
      @(posedge clk);
      #1;
    end
    p0 = bus.p;
    bus.out_ready = 1'b1;
    @(posedge clk);
    #1;
    bus.out_ready = 1'b0;
    if (exp_q.size() == 0) begin
      check({tag, " unexpected output"}, 64'd1, 64'd0);
    end else begin
      e = exp_q.pop_front();
      check(tag, 64'(p0), 64'(e));
      $display("[TB] %s p=%h expected=%h", tag, p0, e);
    end
    check({tag, " out_valid drop"}, 64'(bus.out_valid), 64'd0);
    check({tag, " in_ready back"}, 64'(bus.in_ready), 64'd1);
  endtask

  task automatic run_op(input string tag, input logic [A_W-1:0] a, input logic [B_W-1:0] b,
                        input logic as, input logic bs, input int stall);
    int lat;
    start_op(a, b, as, bs);
    wait_out(lat);
    check({tag, " latency"}, 64'(lat), 64'(LAT));
    finish_op(tag, stall);
  endtask

  initial begin
    int lat;
    logic [P_W-1:0] held;
    rst = 1'b1;
    bus.in_valid = 1'b0; bus.a = '0; bus.b = '0;
    bus.a_signed = 1'b0; bus.b_signed = 1'b0; bus.out_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    check("reset in_ready", 64'(bus.in_ready), 64'd1);
    check("reset out_valid", 64'(bus.out_valid), 64'd0);
    check("reset busy", 64'(bus.busy), 64'd0);
    check("reset p", 64'(bus.p), 64'd0);

    // Directed products, expected values written out independently.
    start_op(16'hFFFD, 8'h05, 1'b1, 1'b1);
    check("ss -3*5 ref", 64'(exp_q[0]), 64'h00FFFFF1);
    wait_out(lat);
    check("ss -3*5 latency", 64'(lat), 64'd9);
    finish_op("ss -3*5", 0);
    run_op("uu ffff*ff", 16'hFFFF, 8'hFF, 1'b0, 1'b0, 1);
    run_op("su -1*255", 16'hFFFF, 8'hFF, 1'b1, 1'b0, 0);
    run_op("ss 8000*80", 16'h8000, 8'h80, 1'b1, 1'b1, 2);
    run_op("ss 7fff*80", 16'h7FFF, 8'h80, 1'b1, 1'b1, 0);
    run_op("ss 0*80", 16'h0000, 8'h80, 1'b1, 1'b1, 0);
    run_op("us 8000*ff", 16'h8000, 8'hFF, 1'b0, 1'b1, 0);

    // Backpressure with new operands offered while busy.
    start_op(16'h1234, 8'hA5, 1'b1, 1'b0);
    held = exp_q[0];
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      #1;
      bus.in_valid = i[0];
      bus.a = 16'($urandom); bus.b = 8'($urandom);
      bus.a_signed = ~bus.a_signed; bus.b_signed = ~bus.b_signed;
    end
    wait_out(lat);
    bus.in_valid = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk);
      #1;
      check("bp p stable", 64'(bus.p), 64'(held));
      check("bp out_valid", 64'(bus.out_valid), 64'd1);
      check("bp in_ready", 64'(bus.in_ready), 64'd0);
      bus.a = 16'($urandom);
    end
    bus.in_valid = 1'b0;
    finish_op("bp 1234*a5", 0);
    check("bp queue empty", 64'(exp_q.size()), 64'd0);

    // Reset while the step with cnt==4 is pending.
    start_op(16'h7FFF, 8'h7F, 1'b1, 1'b1);
    repeat (4) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    exp_q.delete();
    check("midrst in_ready", 64'(bus.in_ready), 64'd1);
    check("midrst out_valid", 64'(bus.out_valid), 64'd0);
    check("midrst p", 64'(bus.p), 64'd0);
    check("midrst busy", 64'(bus.busy), 64'd0);
    run_op("after rst 100*3", 16'd100, 8'd3, 1'b1, 1'b1, 0);
    check("after rst p=300", 64'(bus.p), 64'd300);

    // Random regression over all mode combinations with random stalls.
    for (int i = 0; i < 2000; i++) begin
      start_op(16'($urandom), 8'($urandom), 1'($urandom), 1'($urandom));
      wait_out(lat);
      finish_op("rand", int'($urandom_range(0, 3)));
    end
    check("final queue empty", 64'(exp_q.size()), 64'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
